// File: rtl/ex2_pkg.sv
// Shared types and constants for the operand sequencer and the multiply-add stage pair.
package ex2_pkg;

   typedef enum logic [2:0] {IDLE, A, B, C, GAP} seq_state_t;

   localparam int unsigned MADD_LATENCY = 3;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_MUL = 3'b010;

endpackage

// File: rtl/operand_sequencer_triple_fifo.sv
// FIFO of packed {a,b,c} operand triples with occupancy count.
module triple_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [3*WIDTH-1:0]       wr_data,
   output logic [3*WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [3*WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]      wptr;
   logic [AW-1:0]      rptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_data = mem[rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (!push_ok && pop_ok)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= wr_data;
   end

endmodule

// File: rtl/operand_sequencer.sv
// Buffers (a,b,c) triples and serialises each as three valid words followed by
// GAP idle cycles, feeding the multiply-add stage's validi/data_in stream.
module operand_sequencer
   import ex2_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [WIDTH-1:0]         in_c,
   output logic                     validi,
   output logic [WIDTH-1:0]         op_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic [15:0]              triples_sent
);

   localparam int unsigned GCW = (GAP > 1) ? $clog2(GAP) : 1;

   if (GAP < 1) begin : g_gap_check
      $error("operand_sequencer: GAP must be >= 1");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("operand_sequencer: DEPTH must be a power of two >= 2");
   end

   seq_state_t           state;
   logic [GCW-1:0]       gap_cnt;
   logic [WIDTH-1:0]     hb;
   logic [WIDTH-1:0]     hc;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [3*WIDTH-1:0]   rd_data;

   // Held low during reset so nothing is accepted while the FIFO is cleared.
   assign in_ready = rst_n & ~full;
   assign push     = in_valid & in_ready;
   assign busy     = (state != IDLE);

   always_comb begin
      pop = 1'b0;
      if (!empty && (state == IDLE || (state == ex2_pkg::GAP && gap_cnt == '0)))
         pop = 1'b1;
   end

   triple_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data ({in_a, in_b, in_c}),
      .rd_data (rd_data),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         validi       <= 1'b0;
         op_data      <= '0;
         hb           <= '0;
         hc           <= '0;
         gap_cnt      <= '0;
         triples_sent <= '0;
      end else begin
         unique case (state)
            A: begin
               validi  <= 1'b1;
               op_data <= hb;
               state   <= B;
            end
            B: begin
               validi  <= 1'b1;
               op_data <= hc;
               state   <= C;
            end
            C: begin
               validi       <= 1'b0;
               op_data      <= '0;
               gap_cnt      <= GCW'(GAP - 1);
               triples_sent <= triples_sent + 1'b1;
               state        <= ex2_pkg::GAP;
            end
            default: begin
               // IDLE, and GAP once its count has expired, share the pop path.
               if (state == ex2_pkg::GAP && gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (pop) begin
                  validi  <= 1'b1;
                  op_data <= rd_data[3*WIDTH-1 -: WIDTH];
                  hb      <= rd_data[2*WIDTH-1 -: WIDTH];
                  hc      <= rd_data[WIDTH-1:0];
                  state   <= A;
               end else begin
                  validi  <= 1'b0;
                  op_data <= '0;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
